// File: rtl/i2c_pkg.sv
// Shared types and constants for the scheduled I2C master.
// Holds the controller state encoding and the quarter-phase values of one SCL bit.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StStop,
    StDone
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_master_sched_if.sv
// Requester-side handshake bundle of the I2C master scheduler.
// The requesters hold the master modport; the scheduler holds the slave modport.
interface i2c_master_sched_if;

  logic [1:0] req;
  logic [1:0] rw;
  logic [6:0] addr0;
  logic [6:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output req, rw, addr0, addr1, wdata0, wdata1,
    input  gnt, busy, done, nack, rdata
  );

  modport slave (
    input  req, rw, addr0, addr1, wdata0, wdata1,
    output gnt, busy, done, nack, rdata
  );

endinterface

// File: rtl/i2c_bit_timer.sv
// Quarter-bit timebase: tick pulses every CLK_DIV cycles while enabled and phase
// steps Q0..Q3; both counters sit at zero whenever the timer is disabled.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign tick  = en && (cnt_q == CW'(CLK_DIV - 1));
  assign phase = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_sched.sv
// Two-requester round-robin I2C master: one single-byte read or write per grant,
// open-drain SCL/SDA generated from the quarter-bit timer.
module i2c_master_sched
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125,
  parameter int unsigned N_REQ   = 2
) (
  input  logic              sysclk,
  input  logic              rst,
  i2c_master_sched_if.slave bus,
  output wire               scl,
  inout  wire               sda
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rr_q, rr_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic [7:0]       rdata_q, rdata_d;

  logic       busy, tick, last, sample, win, scl_low, sda_low, bit_scl_low;
  logic [1:0] phase;

  i2c_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .sysclk (sysclk),
    .rst    (rst),
    .en     (busy),
    .tick   (tick),
    .phase  (phase)
  );

  assign busy        = (state_q != StIdle);
  assign last        = tick && (phase == Q3);
  assign sample      = tick && (phase == Q2);
  assign bit_scl_low = (phase == Q3) || (phase == Q0);

  // Purely decoded from async-reset state, so reset releases the bus in the same cycle.
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy;
  assign bus.done  = (state_q == StDone) ? gnt_q : '0;
  assign bus.nack  = nack_q;
  assign bus.rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    rdata_d  = rdata_q;
    scl_low  = 1'b0;
    sda_low  = 1'b0;
    win      = bus.req[rr_q] ? rr_q : ~rr_q;

    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          rr_d       = ~win;
          rw_d       = bus.rw[win];
          wdata_d    = win ? bus.wdata1 : bus.wdata0;
          shreg_d    = {(win ? bus.addr1 : bus.addr0), bus.rw[win]};
          bitcnt_d   = '0;
          nack_d     = 1'b0;
          rdata_d    = '0;
          state_d    = StStart;
        end
      end
      // Q0/Q1 keep the bus idle so STOP-to-START free time spans four quarters.
      StStart: begin
        sda_low = (phase == Q2) || (phase == Q3);
        scl_low = (phase == Q3);
        if (last) state_d = StAddr;
      end
      StAddr: begin
        scl_low = bit_scl_low;
        sda_low = ~shreg_q[7];
        if (last) begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StAddrAck;
        end
      end
      StAddrAck: begin
        scl_low = bit_scl_low;
        if (sample) ack_d = sda;
        if (last) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            shreg_d = wdata_q;
            state_d = StData;
          end
        end
      end
      StData: begin
        scl_low = bit_scl_low;
        sda_low = ~rw_q & ~shreg_q[7];
        if (sample && rw_q) rdata_d = {rdata_q[6:0], sda};
        if (last) begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StDataAck;
        end
      end
      // On reads the released SDA is the master NACK that ends the transfer.
      StDataAck: begin
        scl_low = bit_scl_low;
        if (sample) ack_d = sda;
        if (last) begin
          if (!rw_q && ack_q) nack_d = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        scl_low = (phase == Q0);
        sda_low = (phase == Q0) || (phase == Q1);
        if (last) state_d = StDone;
      end
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_q     <= 1'b0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_sched.sv
// Directed bench for i2c_master_sched with a behavioural I2C slave at address 7'h36
// that ACKs writes and returns 8'h3C on reads, plus bus-timing measurement.
module tb_i2c_master_sched;

  logic sysclk;
  logic rst;
  wire  scl;
  wire  sda;

  i2c_master_sched_if bus ();

  i2c_master_sched #(
    .CLK_DIV (125),
    .N_REQ   (2)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus),
    .scl    (scl),
    .sda    (sda)
  );

  pullup (scl);
  pullup (sda);

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int passed = 0;

  // ---------------- slave model and bus monitor ----------------
  typedef enum logic [2:0] {SIdle, SAddr, SAckA, SWr, SAckW, SRd, SAckM} sl_e;

  sl_e        sl_st = SIdle;
  logic       sl_oe = 1'b0;
  logic [7:0] sl_sh = '0;
  logic [7:0] rd_sh = '0;
  logic [7:0] sl_addr_byte = '0;
  logic [7:0] sl_wr_byte = '0;
  logic       sl_rw = 1'b0;
  logic       m_ack = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       fall_pend = 1'b0;
  logic       s, d;
  int sl_bits = 0, scl_rises = 0, stop_cnt = 0, cyc = 0;
  int t_start = 0, t_rise = 0, t_stop = 0;
  int start_hold = 0, scl_per = 0, stop_setup = 0, bus_free = 0;

  assign sda = sl_oe ? 1'b0 : 1'bz;

  always @(negedge sysclk) begin
    cyc++;
    s = scl;
    d = sda;
    if (s && prev_scl && prev_sda && !d) begin
      sl_st     = SAddr;
      sl_bits   = 0;
      sl_sh     = '0;
      sl_oe     = 1'b0;
      m_ack     = 1'b0;
      scl_rises = 0;
      bus_free  = cyc - t_stop;
      t_start   = cyc;
      fall_pend = 1'b1;
    end else if (s && prev_scl && !prev_sda && d) begin
      sl_st      = SIdle;
      sl_oe      = 1'b0;
      stop_cnt++;
      t_stop     = cyc;
      stop_setup = cyc - t_rise;
    end else if (s && !prev_scl) begin
      scl_rises++;
      if (scl_rises == 2) scl_per = cyc - t_rise;
      t_rise = cyc;
      case (sl_st)
        SAddr, SWr: begin
          sl_sh = {sl_sh[6:0], d};
          sl_bits++;
        end
        SRd:     sl_bits++;
        SAckM:   m_ack = d;
        default: ;
      endcase
    end else if (!s && prev_scl) begin
      if (fall_pend) begin
        start_hold = cyc - t_start;
        fall_pend  = 1'b0;
      end
      case (sl_st)
        SAddr: if (sl_bits == 8) begin
          sl_addr_byte = sl_sh;
          if (sl_sh[7:1] == 7'h36) begin
            sl_rw = sl_sh[0];
            sl_oe = 1'b1;
            sl_st = SAckA;
          end else begin
            sl_st = SIdle;
          end
        end
        SAckA: begin
          sl_bits = 0;
          sl_sh   = '0;
          if (sl_rw) begin
            rd_sh = 8'h3C;
            sl_oe = ~rd_sh[7];
            sl_st = SRd;
          end else begin
            sl_oe = 1'b0;
            sl_st = SWr;
          end
        end
        SWr: if (sl_bits == 8) begin
          sl_wr_byte = sl_sh;
          sl_oe      = 1'b1;
          sl_st      = SAckW;
        end
        SAckW: begin
          sl_oe = 1'b0;
          sl_st = SIdle;
        end
        SRd: begin
          if (sl_bits == 8) begin
            sl_oe = 1'b0;
            sl_st = SAckM;
          end else begin
            rd_sh = {rd_sh[6:0], 1'b0};
            sl_oe = ~rd_sh[7];
          end
        end
        SAckM:   sl_st = SIdle;
        default: ;
      endcase
    end
    prev_scl = s;
    prev_sda = d;
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ge(input string tag, input int obs, input int min);
    checks++;
    assert (obs >= min) passed++;
    else $error("FAIL %s: observed %0d required >= %0d", tag, obs, min);
  endtask

  task automatic wait_gnt(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sysclk);
      if (bus.gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sysclk);
      if (bus.done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  logic ok;
  int   stops0;

  initial begin
    rst        = 1'b0;
    bus.req    = 2'b00;
    bus.rw     = 2'b00;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    repeat (3) @(negedge sysclk);

    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_nack", bus.nack, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);

    // Write 8'hA5 to 7'h36 from requester 0.
    bus.rw     = 2'b00;
    bus.addr0  = 7'h36;
    bus.wdata0 = 8'hA5;
    stops0     = stop_cnt;
    bus.req    = 2'b01;
    wait_gnt(10, ok);
    chk("w_gnt_seen", ok, 1'b1);
    chk("w_gnt", bus.gnt, 2'b01);
    chk("w_busy", bus.busy, 1'b1);
    bus.req = 2'b00;
    wait_done(20000, ok);
    chk("w_done_seen", ok, 1'b1);
    chk("w_done", bus.done, 2'b01);
    chk("w_nack", bus.nack, 1'b0);
    chk("w_addr_byte", sl_addr_byte, 8'h6C);
    chk("w_data_byte", sl_wr_byte, 8'hA5);
    chk("w_stop", stop_cnt - stops0, 1);
    // 8 addr + ack + 8 data + ack + the STOP rise.
    chk("w_scl_rises", scl_rises, 19);
    chk("w_scl_period", scl_per, 500);
    chk_ge("w_start_hold", start_hold, 125);
    chk_ge("w_stop_setup", stop_setup, 125);
    @(negedge sysclk);
    chk("w_done_one_cycle", bus.done, 2'b00);
    chk("w_busy_clear", bus.busy, 1'b0);
    chk("w_gnt_clear", bus.gnt, 2'b00);

    // Read from 7'h36 by requester 1; slave returns 8'h3C.
    bus.rw    = 2'b10;
    bus.addr1 = 7'h36;
    stops0    = stop_cnt;
    bus.req   = 2'b10;
    wait_gnt(10, ok);
    chk("r_gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    wait_done(20000, ok);
    chk("r_done_seen", ok, 1'b1);
    chk("r_done", bus.done, 2'b10);
    chk("r_nack", bus.nack, 1'b0);
    chk("r_rdata", bus.rdata, 8'h3C);
    chk("r_addr_byte", sl_addr_byte, 8'h6D);
    chk("r_master_nack", m_ack, 1'b1);
    chk("r_stop", stop_cnt - stops0, 1);
    @(negedge sysclk);
    chk("r_rdata_hold", bus.rdata, 8'h3C);

    // Address NACK: nobody at 7'h20.
    bus.rw    = 2'b00;
    bus.addr0 = 7'h20;
    stops0    = stop_cnt;
    bus.req   = 2'b01;
    wait_gnt(10, ok);
    chk("n_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    wait_done(20000, ok);
    chk("n_done_seen", ok, 1'b1);
    chk("n_done", bus.done, 2'b01);
    chk("n_nack", bus.nack, 1'b1);
    chk("n_addr_byte", sl_addr_byte, 8'h40);
    // 8 addr + ack + the STOP rise, no data clocks.
    chk("n_scl_rises", scl_rises, 10);
    chk("n_stop", stop_cnt - stops0, 1);

    // Contention from reset with both requests held.
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    rst       = 1'b1;
    bus.addr0 = 7'h20;
    bus.addr1 = 7'h20;
    bus.rw    = 2'b00;
    bus.req   = 2'b11;
    wait_gnt(10, ok);
    chk("c_gnt1", bus.gnt, 2'b01);
    wait_done(20000, ok);
    chk("c_done1", bus.done, 2'b01);
    chk("c_nack1", bus.nack, 1'b1);
    @(negedge sysclk);
    wait_gnt(10, ok);
    chk("c_gnt2", bus.gnt, 2'b10);
    chk("c_nack_cleared", bus.nack, 1'b0);
    wait_done(20000, ok);
    chk("c_done2", bus.done, 2'b10);
    chk_ge("c_bus_free", bus_free, 500);
    @(negedge sysclk);
    wait_gnt(10, ok);
    chk("c_gnt3", bus.gnt, 2'b01);
    bus.req = 2'b00;
    wait_done(20000, ok);
    chk("c_done3", bus.done, 2'b01);
    repeat (3) @(negedge sysclk);

    // Reset during the 4th address bit, then a clean write.
    bus.addr0  = 7'h36;
    bus.wdata0 = 8'h5A;
    bus.req    = 2'b01;
    wait_gnt(10, ok);
    bus.req = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge sysclk);
      if (scl_rises == 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("x_bit4_seen", ok, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("x_scl_rel", scl, 1'b1);
    chk("x_sda_rel", sda, 1'b1);
    chk("x_gnt", bus.gnt, 2'b00);
    chk("x_busy", bus.busy, 1'b0);
    @(negedge sysclk);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    bus.req = 2'b01;
    wait_gnt(10, ok);
    chk("x_gnt_after", bus.gnt, 2'b01);
    bus.req = 2'b00;
    wait_done(20000, ok);
    chk("x_done", bus.done, 2'b01);
    chk("x_nack", bus.nack, 1'b0);
    chk("x_addr_byte", sl_addr_byte, 8'h6C);
    chk("x_data_byte", sl_wr_byte, 8'h5A);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
